keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  Drives the row lines of a 4x4 matrix keypad one at a time (active-low) and samples the column lines.
//  Debounces the result over full scans and emits a 4-bit key code with a one-cycle press strobe.
//  Sits between the physical keypad pins and the keypad consumer logic.
//  Uses the same row/column-to-code map as the keypad decoder in this codebase.
// PARAMETERS
//  SCAN_DIV        1000  clocks per row slot; legal range >= 4.
//  SETTLE          3     slot cycle (div value) at which the columns are sampled; 2 <= SETTLE < SCAN_DIV.
//  DEBOUNCE_SCANS  4     consecutive identical full-scan results needed to change the debounced state; >= 1.
// PORTS
//  clk        in   1  system clock; the only clock.
//  rst_n      in   1  asynchronous, active-low reset.
//  col_n      in   4  raw column inputs, active-low, asynchronous to clk.
//  row_n      out  4  row drive, active-low; exactly one bit is 0 at all times.
//  key_code   out  4  debounced key code; holds its last value after release.
//  key_valid  out  1  one-cycle pulse when a new debounced key is accepted.
//  key_held   out  1  high while a debounced key is pressed.
//  key_rel    out  1  one-cycle release pulse (only when KEYPAD_RELEASE_EN is defined, else tied 0).
// BEHAVIOUR
//  - Reset values: row_n=4'b1110, row index=0, div=0, key_code=0, key_valid=0, key_held=0, key_rel=0.
//    Debounce counter, previous-scan result and debounced state all clear to "no key".
//  - col_n passes through a 2-FF synchronizer. The synchronizer resets to 4'hF.
//  - div counts 0..SCAN_DIV-1 in each row slot.
//    At wrap: row index advances 0->1->2->3->0 and row_n=~(4'b0001<<idx).
//    One full scan takes 4*SCAN_DIV cycles.
//  - Sampling: when div==SETTLE, the synchronized columns are sampled, and only if no hit has been latched yet in this scan.
//    If any column is 0, latch hit=1 and the code for (idx, lowest 0 column).
//    Row priority therefore goes 0>1>2>3 and column priority 0>1>2>3.
//  - Code map (row,col -> code):
//      R0: 1, 2, 3, A
//      R1: 4, 5, 6, B
//      R2: 7, 8, 9, C
//      R3: E, 0, F, D
//    key '0' is code 0; it is distinguished from "no key" by key_valid/key_held.
//  - End of scan (div==SCAN_DIV-1 with idx==3):
//    - Form the scan result {hit, code}, then clear hit for the next scan.
//    - If the result equals the previous scan result, cnt=min(cnt+1, DEBOUNCE_SCANS); else cnt=1.
//    - Store the result as the previous scan result.
//    - When cnt==DEBOUNCE_SCANS and the result differs from the debounced state, the debounced state takes the result.
//      All output changes for that update appear on the next clock edge:
//        none -> K : key_code=K, key_held=1, key_valid pulses for 1 cycle.
//        K -> none : key_held=0, key_code holds, no key_valid; key_rel pulses if enabled.
//        K -> J    : key_code=J, key_valid pulses, key_held stays 1; key_rel pulses for K if enabled.
//  - key_valid is asserted at most once per scan period. There is no back-pressure: the consumer must sample the pulse.
//  - Press latency: DEBOUNCE_SCANS full scans from the first scan that sees the key, plus 1 cycle.
//  - Async reset mid-scan or mid-debounce aborts everything. No pulse is generated from the partial state.
//    Scanning restarts at row 0.
// CONFIGURATION
//  KEYPAD_RELEASE_EN defined: key_rel pulses for 1 cycle on K->none and on K->J. key_code still shows the new key on K->J.
//  Not defined: key_rel is constant 0 and no release logic is built.
// TESTING (bench: SCAN_DIV=8, SETTLE=3, DEBOUNCE_SCANS=2; scan period 32 clk; keypad model pulls col_n[c]=0 while row_n[r]==0)
//  1. Reset, no keys -> row_n=1110,1101,1011,0111 for 8 clk each, repeating. key_valid/key_held/key_code stay 0.
//  2. Hold R1C2 for 4 scans, then release ->
//     - press: one key_valid pulse with key_code=6, key_held=1;
//     - release: key_held=0 two scans after release, key_code stays 6, no key_valid.
//  3. R3C3 present on alternate scans for 3 scans, then stable ->
//     - no key_valid during the bounce;
//     - exactly one key_valid with key_code=D after 2 stable scans.
//  4. R0C3+R2C0 together -> key_code=A. R3C0+R3C2 together -> key_code=E.
//  5. R1C1 held, then switched directly to R2C2 ->
//     - key_valid with 5, then key_valid with 9;
//     - key_held stays 1 throughout;
//     - with KEYPAD_RELEASE_EN, key_rel pulses in the same cycle as the second key_valid.
//  6. rst_n=0 after 1 of 2 debounce scans of R0C0 ->
//     - all outputs return to reset values with no pulse;
//     - after release of reset, key_valid with 1 needs 2 full scans again.

Source files
------------

// File: rtl/keypad_scanner.sv
// Keypad scanner: walks the 4x4 matrix rows, samples columns, and debounces over full scans.
// Define KEYPAD_RELEASE_EN to build the key_rel release pulse; otherwise key_rel is tied 0.
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int SETTLE         = 3,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       key_rel
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_SMPL = DIV_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

  logic [3:0]       colMeta_q, colSync_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic             hit_q, hit_d;
  logic [3:0]       hitCode_q, hitCode_d;
  logic [4:0]       prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       deb_q, deb_d;
  logic [3:0]       keyCode_q, keyCode_d;
  logic             keyValid_q, keyValid_d;
  logic             keyHeld_q, keyHeld_d;
`ifdef KEYPAD_RELEASE_EN
  logic             keyRel_q, keyRel_d;
`endif

  logic       slotEnd, scanEnd, sampleHit;
  logic [3:0] sampleCode;
  logic [4:0] result;

  function automatic logic [1:0] lowestZero(input logic [3:0] cols);
    logic [1:0] col;
    col = 2'd0;
    casez (cols)
      4'b???0: col = 2'd0;
      4'b??01: col = 2'd1;
      4'b?011: col = 2'd2;
      default: col = 2'd3;
    endcase
    return col;
  endfunction

  function automatic logic [3:0] mapCode(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Column inputs are asynchronous to clk; idle (all high) out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colMeta_q <= 4'hF;
      colSync_q <= 4'hF;
    end else begin
      colMeta_q <= col_n;
      colSync_q <= colMeta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      idx_q      <= 2'd0;
      hit_q      <= 1'b0;
      hitCode_q  <= 4'h0;
      prev_q     <= 5'd0;
      cnt_q      <= '0;
      deb_q      <= 5'd0;
      keyCode_q  <= 4'h0;
      keyValid_q <= 1'b0;
      keyHeld_q  <= 1'b0;
    end else begin
      div_q      <= div_d;
      idx_q      <= idx_d;
      hit_q      <= hit_d;
      hitCode_q  <= hitCode_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      keyCode_q  <= keyCode_d;
      keyValid_q <= keyValid_d;
      keyHeld_q  <= keyHeld_d;
    end
  end

`ifdef KEYPAD_RELEASE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keyRel_q <= 1'b0;
    end else begin
      keyRel_q <= keyRel_d;
    end
  end
`endif

  assign slotEnd    = (div_q == DIV_LAST);
  assign scanEnd    = slotEnd && (idx_q == 2'd3);
  assign sampleHit  = (div_q == DIV_SMPL) && !hit_q && (colSync_q != 4'hF);
  assign sampleCode = mapCode(idx_q, lowestZero(colSync_q));
  // A sample landing on the final cycle of the scan still counts toward this scan's result.
  assign result     = sampleHit ? {1'b1, sampleCode} : {hit_q, hitCode_q};

  always_comb begin
    div_d      = slotEnd ? '0 : div_q + DIV_W'(1);
    idx_d      = slotEnd ? idx_q + 2'd1 : idx_q;
    hit_d      = hit_q;
    hitCode_d  = hitCode_q;
    prev_d     = prev_q;
    cnt_d      = cnt_q;
    deb_d      = deb_q;
    keyCode_d  = keyCode_q;
    keyValid_d = 1'b0;
    keyHeld_d  = keyHeld_q;
`ifdef KEYPAD_RELEASE_EN
    keyRel_d   = 1'b0;
`endif

    if (sampleHit) begin
      hit_d     = 1'b1;
      hitCode_d = sampleCode;
    end

    if (scanEnd) begin
      hit_d     = 1'b0;
      hitCode_d = 4'h0;
      prev_d    = result;
      if (result == prev_q) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      end else begin
        cnt_d = CNT_W'(1);
      end

      if ((cnt_d == CNT_MAX) && (result != deb_q)) begin
        deb_d = result;
        if (result[4]) begin
          keyCode_d  = result[3:0];
          keyValid_d = 1'b1;
          keyHeld_d  = 1'b1;
        end else begin
          keyHeld_d  = 1'b0;
        end
`ifdef KEYPAD_RELEASE_EN
        keyRel_d = deb_q[4];
`endif
      end
    end
  end

  assign row_n     = ~(4'b0001 << idx_q);
  assign key_code  = keyCode_q;
  assign key_valid = keyValid_q;
  assign key_held  = keyHeld_q;
`ifdef KEYPAD_RELEASE_EN
  assign key_rel   = keyRel_q;
`else
  assign key_rel   = 1'b0;
`endif

endmodule
